fpu_issue_ctrl: RTL

Sequences one floating-point/conversion operation at a time through the shared FP datapath and its 5-bit alu_op result mux. Accepts requests over a valid/ready handshake and latches the operands. Drives the mux select, and start-pulses the iterative div/sqrt units. Captures the selected result and returns it over a valid/ready response handshake with an error flag.

---
 rtl/fpu_pkg.sv | 27 ++
 rtl/fpu_issue_ctrl_if.sv | 25 ++
 rtl/fpu_op_decode.sv | 24 ++
 rtl/fpu_issue_ctrl.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the FP issue controller: opcodes, widths and FSM states.
package fpu_pkg;

    localparam int unsigned OP_W   = 5;
    localparam int unsigned DATA_W = 32;

    // Opcodes double as the result mux select.
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00001;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00010;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b00011;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b00100;
    localparam logic [OP_W-1:0] OP_SQRT = 5'b00101;
    localparam logic [OP_W-1:0] OP_MIN  = 5'b00110;
    localparam logic [OP_W-1:0] OP_MAX  = 5'b00111;
    localparam logic [OP_W-1:0] OP_EQ   = 5'b01000;
    localparam logic [OP_W-1:0] OP_LT   = 5'b01001;
    localparam logic [OP_W-1:0] OP_LE   = 5'b01010;
    localparam logic [OP_W-1:0] OP_CONV = 5'b01110;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        ITER,
        RESP
    } fpu_state_e;

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// Request/response handshake bundle between a requester and fpu_issue_ctrl.
interface fpu_issue_ctrl_if;
    import fpu_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [OP_W-1:0]   req_op;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/fpu_op_decode.sv
// Classifies an opcode as fixed-latency, iterative or illegal; exactly one output is high.
module fpu_op_decode
    import fpu_pkg::*;
(
    input  logic [OP_W-1:0] op_i,
    output logic            is_fixed_o,
    output logic            is_iter_o,
    output logic            is_illegal_o
);

    // Opcode class lookup.
    always_comb begin
        is_fixed_o   = 1'b0;
        is_iter_o    = 1'b0;
        is_illegal_o = 1'b0;
        case (op_i)
            OP_ADD, OP_SUB, OP_MUL, OP_MIN, OP_MAX,
            OP_EQ, OP_LT, OP_LE, OP_CONV: is_fixed_o   = 1'b1;
            OP_DIV, OP_SQRT:              is_iter_o    = 1'b1;
            default:                      is_illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Sequences one FP operation at a time: latches operands, drives the result mux select,
// kicks the iterative units and returns the captured result over a response handshake.
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int unsigned FIX_LAT      = 1,
    parameter int unsigned ITER_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    fpu_issue_ctrl_if.slave   bus,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [OP_W-1:0]   alu_op,
    output logic              iter_start,
    input  logic              iter_done,
    input  logic [DATA_W-1:0] float_out,
    output logic              busy
);

    localparam int unsigned FixW  = (FIX_LAT > 1) ? $clog2(FIX_LAT) : 1;
    localparam int unsigned IterW = (ITER_TIMEOUT > 1) ? $clog2(ITER_TIMEOUT) : 1;
    localparam logic [FixW-1:0]  FixLoad  = FixW'(FIX_LAT - 1);
    localparam logic [IterW-1:0] IterLast = IterW'(ITER_TIMEOUT - 1);

    fpu_state_e        state_q, state_d;
    logic [DATA_W-1:0] op_a_q, op_a_d;
    logic [DATA_W-1:0] op_b_q, op_b_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic [FixW-1:0]   fix_cnt_q, fix_cnt_d;
    logic [IterW-1:0]  iter_cnt_q, iter_cnt_d;

    logic is_fixed, is_iter, is_illegal;
    logic req_ready;

    fpu_op_decode u_decode (
        .op_i         (bus.req_op),
        .is_fixed_o   (is_fixed),
        .is_iter_o    (is_iter),
        .is_illegal_o (is_illegal)
    );

    // Ready is withheld while reset is asserted even though the state already reads IDLE.
    assign req_ready     = (state_q == IDLE) && !rst;
    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign op_a          = op_a_q;
    assign op_b          = op_b_q;
    assign alu_op        = alu_op_q;
    assign busy          = (state_q != IDLE);
    // The ITER counter is cleared on entry and only counts up, so zero marks the first cycle.
    assign iter_start    = (state_q == ITER) && (iter_cnt_q == '0);

    // Next-state, operand latch, counters and response capture.
    always_comb begin
        state_d    = state_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        alu_op_d   = alu_op_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        fix_cnt_d  = fix_cnt_q;
        iter_cnt_d = iter_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready) begin
                    op_a_d   = bus.req_a;
                    op_b_d   = bus.req_b;
                    alu_op_d = bus.req_op;
                    if (is_fixed) begin
                        state_d   = EXEC;
                        fix_cnt_d = FixLoad;
                    end else if (is_iter) begin
                        state_d    = ITER;
                        iter_cnt_d = '0;
                    end else if (is_illegal) begin
                        state_d    = RESP;
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                    end
                end
            end
            EXEC: begin
                if (fix_cnt_q == '0) begin
                    state_d    = RESP;
                    rsp_data_d = float_out;
                    rsp_err_d  = 1'b0;
                end else begin
                    fix_cnt_d = fix_cnt_q - FixW'(1);
                end
            end
            ITER: begin
                // A done on the terminal count still counts as success.
                if (iter_done) begin
                    state_d    = RESP;
                    rsp_data_d = float_out;
                    rsp_err_d  = 1'b0;
                end else if (iter_cnt_q == IterLast) begin
                    state_d    = RESP;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                end else begin
                    iter_cnt_d = iter_cnt_q + IterW'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            op_a_q     <= '0;
            op_b_q     <= '0;
            alu_op_q   <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            fix_cnt_q  <= '0;
            iter_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            alu_op_q   <= alu_op_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            fix_cnt_q  <= fix_cnt_d;
            iter_cnt_q <= iter_cnt_d;
        end
    end

endmodule
